aurora_tx_framer: RTL

//  Upstream stage of the 2-lane Aurora 64B framing channel. Buffers a raw 64-bit word stream into

---
 rtl/aurora_tx_framer_if.sv | 23 ++
 rtl/aurora_tx_framer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/aurora_tx_framer_if.sv
// Stream bundle for the Aurora TX framer: raw word input plus the s_axi_tx_* channel output.
// The master modport is the framer's view; slave is the source/sink environment.
interface aurora_tx_framer_if;
  logic [63:0] din_tdata;
  logic        din_tvalid;
  logic        din_tlast;
  logic        din_tready;
  logic [63:0] s_axi_tx_tdata;
  logic [7:0]  s_axi_tx_tkeep;
  logic        s_axi_tx_tlast;
  logic        s_axi_tx_tvalid;
  logic        s_axi_tx_tready;

  modport master (
    input  din_tdata, din_tvalid, din_tlast, s_axi_tx_tready,
    output din_tready, s_axi_tx_tdata, s_axi_tx_tkeep, s_axi_tx_tlast, s_axi_tx_tvalid
  );

  modport slave (
    output din_tdata, din_tvalid, din_tlast, s_axi_tx_tready,
    input  din_tready, s_axi_tx_tdata, s_axi_tx_tkeep, s_axi_tx_tlast, s_axi_tx_tvalid
  );
endinterface

// File: rtl/aurora_tx_framer.sv
// Buffers raw 64-bit words into frames, then sends header + payload to the Aurora TX stream.
// state   | meaning
// IDLE    | empty buffer, waiting for first word while channel is up
// FILL    | collecting words until tlast, full buffer or timeout
// HDR     | header word on the TX stream
// PAYLOAD | streaming buffered words, tlast on the final one
module aurora_tx_framer #(
  parameter int          FRAME_WORDS = 16,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [15:0] HDR_MAGIC   = 16'hA55A
) (
  input  logic               user_clk,
  input  logic               system_rst,
  input  logic               channel_up,
  aurora_tx_framer_if.master bus,
  output logic [15:0]        frame_cnt,
  output logic [7:0]         abort_cnt
);
  localparam int AW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WW-1:0] FW_W     = WW'(FRAME_WORDS);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, FILL, HDR, PAYLOAD} state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   wcnt, wcnt_nxt, rdptr;
  logic [AW-1:0]   waddr;
  logic [TW-1:0]   tmr;
  logic [15:0]     seq;
  logic            run_q;
  logic            rdy, accept, close, beat, in_tx;
  logic [63:0]     tdata_q;
  logic [7:0]      tkeep_q;
  logic            tlast_q, tvalid_q;
  logic [63:0]     fbuf [FRAME_WORDS];

  assign bus.din_tready      = rdy;
  assign bus.s_axi_tx_tdata  = tdata_q;
  assign bus.s_axi_tx_tkeep  = tkeep_q;
  assign bus.s_axi_tx_tlast  = tlast_q;
  assign bus.s_axi_tx_tvalid = tvalid_q;

  always_comb begin
    rdy = 1'b0;
    case (state)
      IDLE:    rdy = channel_up;
      FILL:    rdy = (wcnt < FW_W);
      default: rdy = 1'b0;
    endcase
    // run_q keeps ready low until the first clock after reset
    rdy      = rdy & run_q;
    accept   = rdy & bus.din_tvalid;
    waddr    = (state == IDLE) ? '0 : wcnt[AW-1:0];
    wcnt_nxt = ((state == IDLE) ? '0 : wcnt) + WW'(accept);
    // down-counter reaching zero marks the last cycle of the fill window
    close    = (accept & bus.din_tlast) | (wcnt_nxt == FW_W) |
               ((state == FILL) & (tmr == '0));
    beat     = tvalid_q & bus.s_axi_tx_tready;
    in_tx    = (state == HDR) | (state == PAYLOAD);

    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = close ? HDR : FILL;
      FILL:    if (!channel_up) state_nxt = IDLE;
               else if (close) state_nxt = HDR;
      HDR:     if (!channel_up) state_nxt = IDLE;
               else if (beat) state_nxt = PAYLOAD;
      PAYLOAD: if (!channel_up) state_nxt = IDLE;
               else if (beat & tlast_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (accept) fbuf[waddr] <= bus.din_tdata;
  end

  always_ff @(posedge user_clk or posedge system_rst) begin
    if (system_rst) begin
      state     <= IDLE;
      run_q     <= 1'b0;
      wcnt      <= '0;
      rdptr     <= '0;
      tmr       <= '0;
      seq       <= '0;
      frame_cnt <= '0;
      abort_cnt <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
      wcnt  <= (state_nxt == IDLE) ? '0 : wcnt_nxt;

      if (state == IDLE)
        tmr <= TMR_LOAD;
      else if (state == FILL && tmr != '0)
        tmr <= tmr - TW'(1);

      // output register doubles as the prefetch stage of the buffer read
      if (state != IDLE && state_nxt == IDLE) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        tdata_q  <= '0;
        tkeep_q  <= '0;
      end else if (state_nxt == HDR && !in_tx) begin
        tvalid_q <= 1'b1;
        tkeep_q  <= 8'hFF;
        tlast_q  <= 1'b0;
        tdata_q  <= {HDR_MAGIC, seq, 16'(wcnt_nxt), 16'h0000};
        rdptr    <= '0;
      end else if (in_tx && beat) begin
        tdata_q <= fbuf[rdptr[AW-1:0]];
        tlast_q <= (rdptr == wcnt - WW'(1));
        rdptr   <= rdptr + WW'(1);
      end

      if (state == PAYLOAD && state_nxt == IDLE && channel_up) begin
        seq       <= seq + 16'd1;
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (in_tx && !channel_up && abort_cnt != 8'hFF)
        abort_cnt <= abort_cnt + 8'd1;
    end
  end
endmodule
